inst_fetcher: RTL and testbench

- Front-end stage directly upstream of the decoder: generates sequential PCs and requests 32-bit instructions from the memory controller.
- Buffers returned instructions with their PCs in a small FIFO and presents the head to the decoder, which consumes it when its downstream stations are idle.
- Predicts static not-taken (PC+4). On a redirect from commit it flushes the queue and discards any in-flight fetch.

---
 rtl/inst_fetcher_pkg.sv | 19 +
 rtl/inst_fetcher_queue.sv | 72 +++++++
 rtl/inst_fetcher.sv | 110 +++++++++++
 tb/tb_inst_fetcher.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared widths, empty-value constants and fetch FSM state encodings.
package inst_fetcher_pkg;

  localparam int unsigned addrWidth = 32;
  localparam int unsigned instWidth = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [instWidth-1:0] emptyData = '0;
  localparam logic [addrWidth-1:0] emptyAddr = '0;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_DROP
  } fetch_state_e;

endpackage

// File: rtl/inst_fetcher_queue.sv
// Synchronous FIFO of {pc, inst} entries with flush; head is read combinationally.
module inst_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [INST_W-1:0] push_inst,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  assign head_pc   = pc_mem[head_q];
  assign head_inst = inst_mem[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_pop)  head_d = head_q + PTR_W'(1);
      if (do_push) tail_d = tail_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
      else if (!do_push && do_pop) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      pc_mem[tail_q]   <= push_pc;
      inst_mem[tail_q] <= push_inst;
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Sequential-PC instruction fetch with a one-outstanding memory handshake and redirect.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = addrWidth,
  parameter int unsigned INST_W = instWidth
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              if_jump,
  input  logic [ADDR_W-1:0] jump_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_inst,
  input  logic              if_station_idle,
  output logic              if_get_inst,
  output logic [INST_W-1:0] inst_to_dec,
  output logic [ADDR_W-1:0] pc_to_dec
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              issue, push, flush;
  logic              q_full, q_empty;
  logic [ADDR_W-1:0] q_head_pc;
  logic [INST_W-1:0] q_head_inst;

  inst_queue #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .INST_W(INST_W)
  ) u_queue (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (push),
    .pop      (if_get_inst),
    .flush    (flush),
    .push_pc  (addr_q),
    .push_inst(mem_inst),
    .full     (q_full),
    .empty    (q_empty),
    .head_pc  (q_head_pc),
    .head_inst(q_head_inst)
  );

  assign if_get_inst = !q_empty && if_station_idle && !if_jump;
  assign inst_to_dec = q_empty ? INST_W'(emptyData) : q_head_inst;
  assign pc_to_dec   = q_empty ? ADDR_W'(emptyAddr) : q_head_pc;

  // The IDLE-cycle request is combinational so a redirect reaches memory one
  // cycle later; it is gated by rst_in so mem_req stays low while in reset.
  assign mem_req  = (state_q == FETCH_IDLE) ? issue : TRUE;
  assign mem_addr = (state_q == FETCH_IDLE) ? pc_q : addr_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    issue   = FALSE;
    push    = FALSE;
    flush   = FALSE;
    unique case (state_q)
      FETCH_IDLE: begin
        if (if_jump) begin
          pc_d  = jump_pc;
          flush = TRUE;
        end else if (!q_full && rst_in) begin
          issue   = TRUE;
          addr_d  = pc_q;
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (if_jump) begin
          pc_d    = jump_pc;
          flush   = TRUE;
          state_d = mem_ack ? FETCH_IDLE : FETCH_DROP;
        end else if (mem_ack) begin
          push    = TRUE;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = FETCH_IDLE;
        end
      end
      FETCH_DROP: begin
        if (if_jump) begin
          pc_d  = jump_pc;
          flush = TRUE;
        end
        if (mem_ack) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= FETCH_IDLE;
      pc_q    <= ADDR_W'(emptyAddr);
      addr_q  <= ADDR_W'(emptyAddr);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomised and directed bench for inst_fetcher against a transaction-level model.
module tb_inst_fetcher;

  localparam int unsigned DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        if_jump = 1'b0;
  logic [31:0] jump_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_inst = '0;
  logic        if_station_idle = 1'b0;
  logic        if_get_inst;
  logic [31:0] inst_to_dec;
  logic [31:0] pc_to_dec;

  inst_fetcher #(
    .DEPTH (DEPTH),
    .ADDR_W(32),
    .INST_W(32)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .if_jump        (if_jump),
    .jump_pc        (jump_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_inst       (mem_inst),
    .if_station_idle(if_station_idle),
    .if_get_inst    (if_get_inst),
    .inst_to_dec    (inst_to_dec),
    .pc_to_dec      (pc_to_dec)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: queue of fetched {pc, inst}, next PC, outstanding request.
  logic [63:0] mq[$];
  logic [31:0] m_pc = '0;
  logic [31:0] m_req_addr = '0;
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;

  // Memory responder and stimulus knobs.
  int unsigned lat_k = 2;
  int unsigned lat_cnt = 0;
  bit          mem_hold = 1'b0;
  bit          spur_ack = 1'b0;
  bit          idle_k = 1'b0;
  bit          jump_k = 1'b0;
  logic [31:0] jpc_k = '0;
  logic [31:0] inst_src[$];

  // Last sampled DUT outputs.
  logic        obs_req, obs_get;
  logic [31:0] obs_addr, obs_pc, obs_inst;

  task automatic tick();
    bit          ack, exp_req, exp_get;
    logic [31:0] exp_addr, winst;
    logic [63:0] head;
    ack = m_out ? (lat_cnt == 0 && !mem_hold) : spur_ack;
    if (ack && m_out && !m_stale && inst_src.size() != 0) winst = inst_src.pop_front();
    else if (ack) winst = $urandom();
    else winst = '0;
    if_jump         = jump_k;
    jump_pc         = jpc_k;
    if_station_idle = idle_k;
    mem_ack         = ack;
    mem_inst        = winst;
    exp_req  = m_out || (!jump_k && mq.size() < DEPTH);
    exp_addr = m_out ? m_req_addr : m_pc;
    exp_get  = (mq.size() != 0) && idle_k && !jump_k;
    head     = (mq.size() != 0) ? mq[0] : 64'd0;
    #2;
    obs_req  = mem_req;
    obs_addr = mem_addr;
    obs_get  = if_get_inst;
    obs_pc   = pc_to_dec;
    obs_inst = inst_to_dec;
    check_eq("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) check_eq("mem_addr", mem_addr, exp_addr);
    check_eq("if_get_inst", 32'(if_get_inst), 32'(exp_get));
    check_eq("pc_to_dec", pc_to_dec, head[63:32]);
    check_eq("inst_to_dec", inst_to_dec, head[31:0]);
    @(posedge clk_in);
    if (exp_get) void'(mq.pop_front());
    if (m_out) begin
      if (ack) begin
        if (!m_stale && !jump_k) begin
          mq.push_back({m_req_addr, winst});
          m_pc = m_req_addr + 32'd4;
        end
        m_out = 1'b0;
      end else begin
        if (jump_k) m_stale = 1'b1;
        if (lat_cnt > 0) lat_cnt--;
      end
    end else if (exp_req) begin
      m_out      = 1'b1;
      m_stale    = 1'b0;
      m_req_addr = m_pc;
      lat_cnt    = lat_k - 1;
    end
    if (jump_k) begin
      m_pc = jpc_k;
      mq.delete();
    end
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    if_jump = 1'b0; jump_pc = '0; mem_ack = 1'b0; mem_inst = '0; if_station_idle = 1'b0;
    jump_k = 1'b0; jpc_k = '0; idle_k = 1'b0; mem_hold = 1'b0; spur_ack = 1'b0;
    mq.delete(); inst_src.delete();
    m_pc = '0; m_req_addr = '0; m_out = 1'b0; m_stale = 1'b0; lat_cnt = 0;
    #1;
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_get", 32'(if_get_inst), 32'd0);
    check_eq("rst_inst", inst_to_dec, 32'd0);
    check_eq("rst_pc", pc_to_dec, 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
  endtask

  logic [31:0] t1_inst [3] = '{32'h00000013, 32'h00100093, 32'h00200113};

  initial begin : main
    logic [31:0] gp[$];
    logic [31:0] gi[$];
    bit          found;
    int unsigned n_pop, n_push;

    // Reset then sequential fetch.
    lat_k = 2;
    do_reset();
    inst_src.push_back(t1_inst[0]);
    inst_src.push_back(t1_inst[1]);
    inst_src.push_back(t1_inst[2]);
    idle_k = 1'b1;
    for (int i = 0; i < 40 && gp.size() < 3; i++) begin
      tick();
      if (obs_get) begin
        gp.push_back(obs_pc);
        gi.push_back(obs_inst);
      end
    end
    check_eq("t1_gets", 32'(gp.size()), 32'd3);
    for (int i = 0; i < 3 && i < gp.size(); i++) begin
      check_eq("t1_pc", gp[i], 32'(4 * i));
      check_eq("t1_inst", gi[i], t1_inst[i]);
    end

    // Queue fill with decoder stalled, then a single pop.
    do_reset();
    lat_k = 2;
    idle_k = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      found = (mq.size() == DEPTH);
    end
    check_eq("t2_fill_reach", 32'(found), 32'd1);
    repeat (4) tick();
    check_eq("t2_req_full", 32'(obs_req), 32'd0);
    idle_k = 1'b1;
    tick();
    check_eq("t2_pop", 32'(obs_get), 32'd1);
    idle_k = 1'b0;
    tick();
    check_eq("t2_req_after_pop", 32'(obs_req), 32'd1);
    check_eq("t2_addr_after_pop", obs_addr, 32'h20);

    // Redirect while a request to 0x10 is pending.
    do_reset();
    lat_k = 3;
    idle_k = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (m_out && m_req_addr == 32'h10 && lat_cnt > 0) found = 1'b1;
      else tick();
    end
    check_eq("t3_reach", 32'(found), 32'd1);
    jump_k = 1'b1; jpc_k = 32'h1000;
    tick();
    jump_k = 1'b0;
    tick();
    check_eq("t3_get_after", 32'(obs_get), 32'd0);
    check_eq("t3_pc_after", obs_pc, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = obs_req && (obs_addr != 32'h10);
    end
    check_eq("t3_new_req", 32'(found), 32'd1);
    check_eq("t3_new_addr", obs_addr, 32'h1000);

    // Redirect coinciding with an ack.
    do_reset();
    lat_k = 2;
    idle_k = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && lat_cnt == 0) found = 1'b1;
      else tick();
    end
    check_eq("t4_reach", 32'(found), 32'd1);
    jump_k = 1'b1; jpc_k = 32'h2000;
    tick();
    jump_k = 1'b0;
    tick();
    check_eq("t4_req", 32'(obs_req), 32'd1);
    check_eq("t4_addr", obs_addr, 32'h2000);
    check_eq("t4_no_push", obs_pc, 32'd0);

    // Asynchronous reset mid-WAIT with three queued entries.
    do_reset();
    lat_k = 3;
    idle_k = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      found = (mq.size() == 3) && m_out;
    end
    check_eq("t5_reach", 32'(found), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check_eq("t5_async_req", 32'(mem_req), 32'd0);
    check_eq("t5_async_addr", mem_addr, 32'd0);
    check_eq("t5_async_pc", pc_to_dec, 32'd0);
    check_eq("t5_async_inst", inst_to_dec, 32'd0);
    do_reset();
    lat_k = 2;
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    check_eq("t5_restart_req", 32'(obs_req), 32'd1);
    check_eq("t5_restart_addr", obs_addr, 32'd0);
    repeat (6) tick();

    // Push and pop together at count 4 across pointer wrap.
    do_reset();
    lat_k = 2;
    idle_k = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      found = (mq.size() == 4);
    end
    check_eq("t6_reach", 32'(found), 32'd1);
    n_push = 0;
    for (int i = 0; i < 200 && n_push < 20; i++) begin
      idle_k = m_out && lat_cnt == 0;
      if (idle_k) n_push++;
      tick();
    end
    check_eq("t6_pushes", n_push, 32'd20);
    mem_hold = 1'b1;
    idle_k = 1'b1;
    n_pop = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_get) n_pop++;
    end
    check_eq("t6_count", n_pop, 32'd4);
    mem_hold = 1'b0;

    // Randomised traffic with redirects, stalls and PC wrap.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      lat_k  = $urandom_range(1, 4);
      idle_k = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      jump_k = ($urandom_range(0, 39) == 0);
      jpc_k  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
